imem_uart_tx: RTL and testbench

Instruction-memory readback transmitter: the return path of the UART instruction loader. On a `start` pulse it reads `len` consecutive bytes from instruction memory through a synchronous read port and sends them over a 8N1 UART line. The bytes are preceded by the ASCII header "TECTUINNO", so the host can confirm what the loader actually wrote. It sits beside the loader and shares the board's system clock and TX pin mux.

---
 rtl/imem_uart_tx_if.sv | 38 +++
 rtl/imem_uart_tx.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_imem_uart_tx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_uart_tx_if.sv
// imem_uart_tx_if: bundles the dump request, imem read port and UART line of imem_uart_tx.
// master = host/imem side (drives start, len, mem_data); slave = the transmitter.
interface imem_uart_tx_if #(
  parameter int unsigned AW = 6
) ();

  logic          start;
  logic [AW:0]   len;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          tx;
  logic          busy;
  logic          done;

  modport master (
    output start,
    output len,
    output mem_data,
    input  mem_rd,
    input  mem_addr,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  len,
    input  mem_data,
    output mem_rd,
    output mem_addr,
    output tx,
    output busy,
    output done
  );

endinterface

// File: rtl/imem_uart_tx.sv
// imem_uart_tx: reads len bytes of instruction memory and sends them as 8N1 UART frames,
// preceded by the ASCII header "TECTUINNO".
// Optional feature: define IMEM_UART_TX_CKSUM_EN to append an 8-bit mod-256 payload checksum
// frame after the payload. Without it the checksum logic is not built.
// Reset is synchronous and active-low.
module imem_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 235,
  parameter int unsigned AW           = 6
) (
  input logic          clk,
  input logic          rst,
  imem_uart_tx_if.slave bus
);

  localparam int unsigned    CntW   = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     HdrLen = 4'd9;
  localparam logic [3:0]     LastBit = 4'd9;

  typedef enum logic [1:0] {
    BIdle,
    BBit,
    BDone
  } bstate_e;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StRdReq,
    StRdCap,
    StSend,
    StTail,
    StFin
  } state_e;

  // Header ROM: "TECTUINNO".
  function automatic logic [7:0] hdr_char(input logic [3:0] idx);
    logic [7:0] c;
    unique case (idx)
      4'd0:    c = 8'h54;  // T
      4'd1:    c = 8'h45;  // E
      4'd2:    c = 8'h43;  // C
      4'd3:    c = 8'h54;  // T
      4'd4:    c = 8'h55;  // U
      4'd5:    c = 8'h49;  // I
      4'd6:    c = 8'h4E;  // N
      4'd7:    c = 8'h4E;  // N
      4'd8:    c = 8'h4F;  // O
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Byte engine state.
  bstate_e         b_state_q, b_state_d;
  logic [9:0]      shift_q, shift_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic            tx_q, tx_d;

  // Main FSM state.
  state_e          state_q, state_d;
  logic [AW:0]     len_q, len_d;
  logic [AW:0]     sent_q, sent_d;
  logic [AW:0]     sent_inc;
  logic [AW-1:0]   addr_q, addr_d;
  logic [3:0]      hdr_idx_q, hdr_idx_d;
  logic            hdr_wait_q, hdr_wait_d;
`ifdef IMEM_UART_TX_CKSUM_EN
  logic [7:0]      cksum_q, cksum_d;
  logic            tail_end_q, tail_end_d;
`endif

  // Main FSM -> byte engine.
  logic            launch;
  logic [7:0]      launch_byte;
  logic            b_done;

  assign b_done   = (b_state_q == BDone);
  assign sent_inc = sent_q + (AW+1)'(1);

  // Main FSM: next state, counters and byte launch requests.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sent_d      = sent_q;
    addr_d      = addr_q;
    hdr_idx_d   = hdr_idx_q;
    hdr_wait_d  = hdr_wait_q;
`ifdef IMEM_UART_TX_CKSUM_EN
    cksum_d     = cksum_q;
    tail_end_d  = tail_end_q;
`endif
    launch      = 1'b0;
    launch_byte = hdr_char(hdr_idx_q);

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          len_d      = bus.len;
          sent_d     = '0;
          addr_d     = '0;
          hdr_idx_d  = '0;
          // One dead cycle in HDR puts the first start bit 2 cycles after start.
          hdr_wait_d = 1'b1;
`ifdef IMEM_UART_TX_CKSUM_EN
          cksum_d    = '0;
          tail_end_d = 1'b0;
`endif
          state_d    = StHdr;
        end
      end

      StHdr: begin
        hdr_wait_d = 1'b0;
        if ((b_state_q == BIdle && hdr_idx_q == '0 && !hdr_wait_q) ||
            (b_done && hdr_idx_q != HdrLen)) begin
          launch    = 1'b1;
          hdr_idx_d = hdr_idx_q + 4'd1;
        end else if (b_done) begin
          if (len_q != '0) begin
            state_d = StRdReq;
          end else begin
            state_d = StTail;
`ifdef IMEM_UART_TX_CKSUM_EN
            // Launch straight from B_DONE so the checksum frame has a 1-cycle gap.
            launch      = 1'b1;
            launch_byte = cksum_q;
`endif
          end
        end
      end

      StRdReq: begin
        state_d = StRdCap;
      end

      StRdCap: begin
        launch      = 1'b1;
        launch_byte = bus.mem_data;
`ifdef IMEM_UART_TX_CKSUM_EN
        cksum_d     = cksum_q + bus.mem_data;
`endif
        state_d     = StSend;
      end

      StSend: begin
        if (b_done) begin
          sent_d = sent_inc;
          if (sent_inc < len_q) begin
            // Address only advances when another read follows, so it rests on the last byte.
            addr_d  = addr_q + AW'(1);
            state_d = StRdReq;
          end else begin
            state_d = StTail;
`ifdef IMEM_UART_TX_CKSUM_EN
            launch      = 1'b1;
            launch_byte = cksum_q;
`endif
          end
        end
      end

      StTail: begin
`ifdef IMEM_UART_TX_CKSUM_EN
        // Extra cycle after the checksum stop bit keeps done 2 cycles after the last frame.
        if (tail_end_q) begin
          state_d = StFin;
        end else if (b_done) begin
          tail_end_d = 1'b1;
        end
`else
        state_d = StFin;
`endif
      end

      StFin: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Main FSM registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      sent_q     <= '0;
      addr_q     <= '0;
      hdr_idx_q  <= '0;
      hdr_wait_q <= 1'b0;
`ifdef IMEM_UART_TX_CKSUM_EN
      cksum_q    <= '0;
      tail_end_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      sent_q     <= sent_d;
      addr_q     <= addr_d;
      hdr_idx_q  <= hdr_idx_d;
      hdr_wait_q <= hdr_wait_d;
`ifdef IMEM_UART_TX_CKSUM_EN
      cksum_q    <= cksum_d;
      tail_end_q <= tail_end_d;
`endif
    end
  end

  // Byte engine: shifts a 10-bit start/data/stop frame out, CLKS_PER_BIT cycles per bit.
  always_comb begin
    b_state_d = b_state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    clk_cnt_d = clk_cnt_q;
    tx_d      = 1'b1;

    unique case (b_state_q)
      BIdle, BDone: begin
        if (launch) begin
          b_state_d = BBit;
          shift_d   = {1'b1, launch_byte, 1'b0};
          bit_cnt_d = '0;
          clk_cnt_d = '0;
        end else begin
          b_state_d = BIdle;
        end
      end

      BBit: begin
        if (clk_cnt_q == CntMax) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == LastBit) begin
            b_state_d = BDone;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shift_d   = {1'b1, shift_q[9:1]};
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end

      default: begin
        b_state_d = BIdle;
      end
    endcase

    // Line is driven from a flop so the pin never glitches.
    if (b_state_d == BBit) begin
      tx_d = shift_d[0];
    end
  end

  // Byte engine registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      b_state_q <= BIdle;
      shift_q   <= '1;
      bit_cnt_q <= '0;
      clk_cnt_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      b_state_q <= b_state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      clk_cnt_q <= clk_cnt_d;
      tx_q      <= tx_d;
    end
  end

  assign bus.tx       = tx_q;
  assign bus.mem_rd   = (state_q == StRdReq);
  assign bus.mem_addr = addr_q;
  assign bus.busy     = (state_q != StIdle) && (state_q != StFin);
  assign bus.done     = (state_q == StFin);

endmodule

// File: tb/tb_imem_uart_tx.sv
// tb_imem_uart_tx: directed bench for imem_uart_tx with CLKS_PER_BIT=8, AW=6.
// Dump latency is measured from the edge where tx first falls to the edge where done rises:
// 9*(10*CPB+1) + len*(10*CPB+3) + 1 cycles, plus 10*CPB+1 for the checksum frame when enabled.
module tb_imem_uart_tx;

  localparam int unsigned CPB   = 8;
  localparam int unsigned AW    = 6;
  localparam int          Frame = 10 * CPB;
`ifdef IMEM_UART_TX_CKSUM_EN
  localparam bit CkEn = 1'b1;
`else
  localparam bit CkEn = 1'b0;
`endif

  logic clk;
  logic rst;

  imem_uart_tx_if #(.AW(AW)) bus ();

  imem_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .AW          (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [64];
  logic [7:0] hdr [9] = '{8'h54, 8'h45, 8'h43, 8'h54, 8'h55, 8'h49, 8'h4E, 8'h4E, 8'h4F};

  logic [7:0]    rx_q [$];
  logic [AW-1:0] rd_addrs [$];
  int            done_cnt = 0;
  int            frame_errs = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Synchronous imem: data valid the cycle after mem_rd, junk otherwise.
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
    else            bus.mem_data <= 8'hEE;
  end

  // Event monitor.
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    if (bus.mem_rd === 1'b1) rd_addrs.push_back(bus.mem_addr);
  end

  // UART receiver sampling mid-bit.
  initial begin : uart_rx
    logic [7:0] b;
    b = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && bus.tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = bus.tx;
        end
        repeat (CPB) @(negedge clk);
        rx_q.push_back(b);
        if (bus.tx !== 1'b1) frame_errs++;
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Runs one dump of n bytes from mem[0..n-1]; optionally retriggers start with len=5 mid-header.
  task automatic run_dump(input string tag, input int n, input logic [7:0] exp_ck,
                          input bit retrig);
    logic [7:0] exp_q [$];
    int rx_base, rd_base, done_base, cnt, exp_cyc;
    rx_base   = rx_q.size();
    rd_base   = rd_addrs.size();
    done_base = done_cnt;
    for (int i = 0; i < 9; i++) exp_q.push_back(hdr[i]);
    for (int i = 0; i < n; i++) exp_q.push_back(mem[i]);
    if (CkEn) exp_q.push_back(exp_ck);
    exp_cyc = 9 * (Frame + 1) + n * (Frame + 3) + 1 + (CkEn ? Frame + 1 : 0) + 2;

    @(negedge clk);
    bus.len   = (AW+1)'(n);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check_eq({tag, " busy after start"}, 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1 check_eq({tag, " tx idle 1 cycle after start"}, 32'(bus.tx), 32'd1);
    @(posedge clk);
    #1 check_eq({tag, " first start bit at 2 cycles"}, 32'(bus.tx), 32'd0);
    cnt = 2;
    while (bus.done !== 1'b1 && cnt < exp_cyc + 50) begin
      if (retrig && cnt == 100) begin
        bus.start = 1'b1;
        bus.len   = 7'd5;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1 cnt++;
    end
    bus.start = 1'b0;
    check_eq({tag, " cycles start to done"}, 32'(cnt), 32'(exp_cyc));
    check_eq({tag, " busy low with done"}, 32'(bus.busy), 32'd0);
    check_eq({tag, " tx idle at done"}, 32'(bus.tx), 32'd1);
    @(posedge clk);
    #1 check_eq({tag, " done is one pulse"}, 32'(bus.done), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check_eq({tag, " done pulse count"}, 32'(done_cnt - done_base), 32'd1);
    check_eq({tag, " byte count"}, 32'(rx_q.size() - rx_base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rx_base + i < rx_q.size())
        check_eq($sformatf("%s byte %0d", tag, i), 32'(rx_q[rx_base + i]), 32'(exp_q[i]));
    end
    check_eq({tag, " mem_rd count"}, 32'(rd_addrs.size() - rd_base), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (rd_base + i < rd_addrs.size())
        check_eq($sformatf("%s rd addr %0d", tag, i), 32'(rd_addrs[rd_base + i]), 32'(i));
    end
    check_eq({tag, " final mem_addr"}, 32'(bus.mem_addr), (n == 0) ? 32'd0 : 32'(n - 1));
    repeat (20) @(posedge clk);
  endtask

  initial begin : stim
    int done_base, bound;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.len   = '0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;

    // Reset hold, release, and stay idle.
    repeat (5) @(posedge clk);
    #1;
    check_eq("reset tx", 32'(bus.tx), 32'd1);
    check_eq("reset busy", 32'(bus.busy), 32'd0);
    check_eq("reset done", 32'(bus.done), 32'd0);
    check_eq("reset mem_rd", 32'(bus.mem_rd), 32'd0);
    check_eq("reset mem_addr", 32'(bus.mem_addr), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    begin
      int bad;
      bad = 0;
      repeat (200) begin
        @(negedge clk);
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mem_rd !== 1'b0)
          bad++;
      end
      check_eq("idle outputs stay quiet", 32'(bad), 32'd0);
    end
    check_eq("idle no bytes", 32'(rx_q.size()), 32'd0);

    // len=3 basic dump.
    mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'hA5;
    run_dump("len3", 3, 8'hB8, 1'b0);

    // Header only.
    run_dump("len0", 0, 8'h00, 1'b0);

    // Full memory, address wrap boundary.
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    run_dump("len64", 64, 8'hE0, 1'b0);

    // Start during header with a different len is ignored.
    mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'hA5;
    run_dump("retrig", 3, 8'hB8, 1'b1);

    // Reset during data bit 0 of payload byte 1 (0x00).
    done_base = done_cnt;
    @(negedge clk);
    bus.len   = 7'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bound = 0;
    while (!(bus.mem_rd === 1'b1 && bus.mem_addr == 6'd1) && bound < 3000) begin
      @(negedge clk);
      bound++;
    end
    check_eq("rstmid reached read of byte 1", 32'(bound < 3000), 32'd1);
    repeat (2 + CPB + 3) @(posedge clk);
    @(negedge clk);
    check_eq("rstmid tx low before reset", 32'(bus.tx), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rstmid tx after reset", 32'(bus.tx), 32'd1);
    check_eq("rstmid busy after reset", 32'(bus.busy), 32'd0);
    check_eq("rstmid mem_rd after reset", 32'(bus.mem_rd), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    check_eq("rstmid no done", 32'(done_cnt - done_base), 32'd0);
    check_eq("rstmid line idle", 32'(bus.tx), 32'd1);

    // Full dump after the interrupted one.
    run_dump("after_rst", 3, 8'hB8, 1'b0);

    check_eq("framing errors", 32'(frame_errs), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
